shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Sequencing controller for the team's W-stage serial shift register, built as a chain of master-slave latch stages with a shift-enable and a clear.
- Accepts one command at a time: clear the register, serially load a parallel word, or run the register as a Fibonacci LFSR for N steps.
- Drives the register's serial input, shift enable and clear, then returns the resulting register contents with a done pulse.
- Sits between the register and any bus-side or test logic that needs parallel access to it.

Parameters:
- W, 8, register length in stages; legal range 2..32.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- r  in  1  reset; asynchronous, active-low.
- start  in  1  command request; sampled only in IDLE.
- mode  in  2  command: 0 CLEAR, 1 LOAD, 2 LFSR, 3 reserved.
- data_in  in  W  word to serialize (LOAD).
- taps  in  W  LFSR tap mask; bit i selects stage i.
- run_len  in  8  number of LFSR steps (0..255).
- sr_q  in  W  parallel stage outputs of the register; bit 0 is the first stage.
- sr_si  out  1  serial input to stage 0.
- sr_shift_en  out  1  register shifts on the next edge when 1.
- sr_clr  out  1  synchronous clear of all stages.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes.
- data_out  out  W  sr_q captured at command completion; held until the next completion.

Behaviour:
- Reset (r=0, asynchronous) forces state to IDLE and sets busy=0, done=0, data_out=0, sr_si=0, sr_shift_en=0, sr_clr=0.
- Register shift convention: on each enabled edge, sr_q becomes {sr_q[W-2:0], sr_si}.
- States: IDLE, CLR, SHIFT, LFSR, SETTLE.
- sr_si, sr_shift_en and sr_clr are a Moore decode of registered state, counter and latched operands.
- IDLE:
  - When start=1, latch mode, data_in, taps and run_len.
  - Next state: CLR for mode 0, SHIFT for mode 1, LFSR for mode 2 (SETTLE if run_len=0), SETTLE for mode 3.
  - start=0 keeps the block in IDLE.
- CLR: sr_clr=1 for exactly one cycle, then SETTLE.
- SHIFT:
  - W cycles with sr_shift_en=1 and counter k = 0..W-1.
  - sr_si = data_latched[W-1-k], so the word is sent MSB first and sr_q equals data_in after W shifts.
  - After W cycles, go to SETTLE.
- LFSR:
  - run_len cycles with sr_shift_en=1.
  - sr_si = XOR-reduce of (sr_q & taps_latched).
  - Lock-up guard: if sr_q==0 in the first LFSR cycle, sr_si=1 for that cycle only.
  - After run_len cycles, go to SETTLE.
- SETTLE:
  - One cycle with no shift and no clear.
  - On the exiting edge: data_out <= sr_q, done <= 1 (registered, lasts one cycle), state <= IDLE.
- Latency from the edge that samples start to the cycle in which done is high:
  - CLEAR: 3 cycles.
  - LOAD: W+2 cycles.
  - LFSR: run_len+2 cycles.
  - Reserved mode, or LFSR with run_len=0: 2 cycles.
- busy falls in the same cycle that done rises; a new start is accepted in that same cycle.
- start while busy=1 is ignored; no queuing.
- Reserved mode performs no register activity; data_out still recaptures sr_q.
- Inputs other than start are don't-care outside the IDLE sampling edge.
- Reset mid-command aborts immediately; no done pulse. The external register's contents are undefined from this block's point of view.
- Counter is 8 bits; no wrap is possible within a command.

Decomposition:
- Package shift_seq_pkg:
  - state enum (IDLE, CLR, SHIFT, LFSR, SETTLE);
  - mode enum with codes 0..3;
  - function lfsr_fb(q, taps) returning the XOR-reduce of the AND.
- No sub-module; single FSM plus an 8-bit counter.
- Bench instantiates a behavioural W-stage enabled/clearable shift register wired to sr_si/sr_shift_en/sr_clr/sr_q.

Test Plan:
- W=8; CLEAR on a register holding 8'hFF, then LOAD with data_in=8'hA5 -> first done at cycle 3 with data_out=8'h00; second done 10 cycles after its start with data_out=8'hA5; sr_si sequence 1,0,1,0,0,1,0,1.
- Register=8'h01, LFSR taps=8'hB8, run_len=4 -> states 02,04,08,11; done at cycle 6; data_out=8'h11.
- Register=8'h00, LFSR taps=8'hB8, run_len=1 -> lock-up seed applied; data_out=8'h01.
- LFSR with run_len=0, and separately mode=3 -> sr_shift_en never high; done at cycle 2; data_out equals the unchanged register.
- Pulse start with mode=2 during LOAD cycle 4 -> ignored; only one done, at cycle 10, with data_out=data_in.
- r=0 asynchronously during LOAD cycle 4 -> busy, sr_shift_en and data_out go to 0 before the next edge; no done; a new LOAD after reset completes normally.

Source files
------------

// File: rtl/shift_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_seq_pkg: shared types and LFSR feedback helper for shift_seq_ctrl |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package shift_seq_pkg;

  localparam int c_max_w = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    SHIFT  = 3'd2,
    LFSR   = 3'd3,
    SETTLE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Callers zero-extend narrower registers to the full width.
  function automatic logic lfsr_fb(input logic [c_max_w-1:0] q,
                                   input logic [c_max_w-1:0] tap_mask);
    return ^(q & tap_mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_seq_ctrl: sequences clear / serial load / LFSR runs on an        |
// | external W-stage shift register and returns its parallel contents.     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         r,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] data_in,
  input  logic [W-1:0] taps,
  input  logic [7:0]   run_len,
  input  logic [W-1:0] sr_q,
  output logic         sr_si,
  output logic         sr_shift_en,
  output logic         sr_clr,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_out
);

  localparam logic [7:0] c_last_bit = 8'(W - 1);

  if (W < 2 || W > c_max_w) begin : g_w_range_check
    $error("shift_seq_ctrl: W must be in 2..32");
  end

  state_e         r_state;
  state_e         w_next_state;
  logic [7:0]     r_cnt;
  logic [W-1:0]   r_data;
  logic [W-1:0]   r_taps;
  logic [7:0]     r_len;
  logic           r_done;
  logic [W-1:0]   r_data_out;
  logic           w_lock_seed;

  // State register, step counter, operand latches and completion outputs.
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_data     <= '0;
      r_taps     <= '0;
      r_len      <= 8'd0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (r_state == IDLE || w_next_state != r_state) ? 8'd0 : r_cnt + 8'd1;
      if (r_state == IDLE && start) begin
        r_data <= data_in;
        r_taps <= taps;
        r_len  <= run_len;
      end else if (r_state == SHIFT) begin
        // Keep the next bit to send at the MSB so the word goes out MSB first.
        r_data <= r_data << 1;
      end
      r_done <= (r_state == SETTLE);
      if (r_state == SETTLE) begin
        r_data_out <= sr_q;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (mode_e'(mode))
            MODE_CLEAR: w_next_state = CLR;
            MODE_LOAD:  w_next_state = SHIFT;
            MODE_LFSR:  w_next_state = (run_len == 8'd0) ? SETTLE : LFSR;
            default:    w_next_state = SETTLE;
          endcase
        end
      end
      CLR:     w_next_state = SETTLE;
      SHIFT:   if (r_cnt == c_last_bit) w_next_state = SETTLE;
      LFSR:    if (r_cnt == r_len - 8'd1) w_next_state = SETTLE;
      SETTLE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // An all-zero register would never leave zero, so seed a 1 on the first step.
  assign w_lock_seed = (r_cnt == 8'd0) && (sr_q == '0);

  always_comb begin
    sr_si       = 1'b0;
    sr_shift_en = 1'b0;
    sr_clr      = 1'b0;
    case (r_state)
      CLR: sr_clr = 1'b1;
      SHIFT: begin
        sr_shift_en = 1'b1;
        sr_si       = r_data[W-1];
      end
      LFSR: begin
        sr_shift_en = 1'b1;
        sr_si       = w_lock_seed ? 1'b1 : lfsr_fb(c_max_w'(sr_q), c_max_w'(r_taps));
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// Self-checking bench for shift_seq_ctrl with a behavioural shift register
// and a command-level reference model.
module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         r;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] data_in;
  logic [W-1:0] taps;
  logic [7:0]   run_len;
  logic [W-1:0] sr_q;
  logic         sr_si;
  logic         sr_shift_en;
  logic         sr_clr;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;

  logic         pre_en;
  logic [W-1:0] pre_val;
  logic [W-1:0] sr_reg;
  logic [W-1:0] model_q;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  always #5 clock = ~clock;

  shift_seq_ctrl #(.W(W)) dut (
    .clock       (clock),
    .r           (r),
    .start       (start),
    .mode        (mode),
    .data_in     (data_in),
    .taps        (taps),
    .run_len     (run_len),
    .sr_q        (sr_q),
    .sr_si       (sr_si),
    .sr_shift_en (sr_shift_en),
    .sr_clr      (sr_clr),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out)
  );

  always @(posedge clock) begin
    if (pre_en)           sr_reg <= pre_val;
    else if (sr_clr)      sr_reg <= '0;
    else if (sr_shift_en) sr_reg <= {sr_reg[W-2:0], sr_si};
  end
  assign sr_q = sr_reg;

  // Command-level reference: final register contents, latency, shift count.
  task automatic model(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] t,
                       input int len, inout logic [W-1:0] q, output int lat, output int nsh);
    logic fb;
    case (m)
      2'd0: begin q = '0; lat = 3; nsh = 0; end
      2'd1: begin q = d; lat = W + 2; nsh = W; end
      2'd2: begin
        nsh = len;
        lat = (len == 0) ? 2 : len + 2;
        for (int i = 0; i < len; i++) begin
          fb = (i == 0 && q == '0) ? 1'b1 : ^(q & t);
          q  = {q[W-2:0], fb};
        end
      end
      default: begin lat = 2; nsh = 0; end
    endcase
  endtask

  task automatic preload(input logic [W-1:0] v);
    @(negedge clock);
    pre_en = 1'b1; pre_val = v;
    @(negedge clock);
    pre_en = 1'b0;
    model_q = v;
  endtask

  // Issues one command and observes it until done (bounded); returns observations.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] t,
                       input logic [7:0] len, input bit b2b, input int poke,
                       output int lat, output logic [W-1:0] dout, output int nsh,
                       output int nclr, output logic [W-1:0] si_bits);
    if (!b2b) @(negedge clock);
    start = 1'b1; mode = m; data_in = d; taps = t; run_len = len;
    @(posedge clock);
    #1;
    start = 1'b0; mode = 2'($urandom); data_in = W'($urandom);
    taps = W'($urandom); run_len = 8'($urandom);
    lat = -1; dout = '0; nsh = 0; nclr = 0; si_bits = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      if (c == poke) begin start = 1'b1; mode = 2'd2; run_len = 8'd3; end
      else start = 1'b0;
      if (sr_shift_en) begin nsh++; si_bits = {si_bits[W-2:0], sr_si}; end
      if (sr_clr) nclr++;
      if (done) begin lat = c; dout = data_out; break; end
    end
    start = 1'b0;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) cnt++;
    end
  endtask

  task automatic test_reset;
    r = 1'b0; start = 1'b0; mode = 2'd0; data_in = '0; taps = '0; run_len = 8'd0;
    pre_en = 1'b0; pre_val = '0;
    repeat (3) @(negedge clock);
    cmp_cnt++;
    if ({busy, done, sr_si, sr_shift_en, sr_clr} !== 5'b0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl: got busy/done/si/en/clr=%b want 00000",
               {busy, done, sr_si, sr_shift_en, sr_clr});
    end
    cmp_cnt++;
    if (data_out !== '0) begin
      fail_cnt++; $display("FAIL reset_data_out: got %h want 00", data_out);
    end
    r = 1'b1;
  endtask

  task automatic test_clear_load;
    int lat, nsh, nclr; logic [W-1:0] dout, si;
    preload(8'hFF);
    issue(2'd0, 8'h00, 8'h00, 8'd0, 1'b0, 0, lat, dout, nsh, nclr, si);
    cmp_cnt++;
    if (lat !== 3) begin fail_cnt++; $display("FAIL clear_lat: got %0d want 3", lat); end
    cmp_cnt++;
    if (dout !== 8'h00) begin fail_cnt++; $display("FAIL clear_data: got %h want 00", dout); end
    cmp_cnt++;
    if (nclr !== 1 || nsh !== 0) begin
      fail_cnt++; $display("FAIL clear_pulses: got clr=%0d en=%0d want 1,0", nclr, nsh);
    end
    issue(2'd1, 8'hA5, 8'h00, 8'd0, 1'b0, 0, lat, dout, nsh, nclr, si);
    cmp_cnt++;
    if (lat !== W + 2) begin fail_cnt++; $display("FAIL load_lat: got %0d want %0d", lat, W + 2); end
    cmp_cnt++;
    if (dout !== 8'hA5) begin fail_cnt++; $display("FAIL load_data: got %h want a5", dout); end
    cmp_cnt++;
    if (si !== 8'hA5 || nsh !== W) begin
      fail_cnt++; $display("FAIL load_si_seq: got %b (%0d shifts) want 10100101 (8)", si, nsh);
    end
  endtask

  task automatic test_lfsr_known;
    int lat, nsh, nclr; logic [W-1:0] dout, si;
    preload(8'h01);
    issue(2'd2, 8'h00, 8'hB8, 8'd4, 1'b0, 0, lat, dout, nsh, nclr, si);
    cmp_cnt++;
    if (lat !== 6) begin fail_cnt++; $display("FAIL lfsr_lat: got %0d want 6", lat); end
    cmp_cnt++;
    if (dout !== 8'h11) begin fail_cnt++; $display("FAIL lfsr_data: got %h want 11", dout); end
    cmp_cnt++;
    if (si[3:0] !== 4'b0001 || nsh !== 4) begin
      fail_cnt++; $display("FAIL lfsr_fb_seq: got %b (%0d shifts) want 0001 (4)", si[3:0], nsh);
    end
  endtask

  task automatic test_lockup;
    int lat, nsh, nclr; logic [W-1:0] dout, si;
    preload(8'h00);
    issue(2'd2, 8'h00, 8'hB8, 8'd1, 1'b0, 0, lat, dout, nsh, nclr, si);
    cmp_cnt++;
    if (dout !== 8'h01 || lat !== 3) begin
      fail_cnt++; $display("FAIL lockup_seed: got data %h lat %0d want 01 lat 3", dout, lat);
    end
  endtask

  task automatic test_zero_len_reserved;
    int lat, nsh, nclr; logic [W-1:0] dout, si, v;
    v = W'($urandom) | 8'h40;
    preload(v);
    issue(2'd2, 8'h00, 8'hB8, 8'd0, 1'b0, 0, lat, dout, nsh, nclr, si);
    cmp_cnt++;
    if (lat !== 2 || nsh !== 0 || dout !== v) begin
      fail_cnt++;
      $display("FAIL lfsr_zero_len: got lat %0d en %0d data %h want 2 0 %h", lat, nsh, dout, v);
    end
    preload(~v);
    issue(2'd3, 8'hFF, 8'hFF, 8'd9, 1'b0, 0, lat, dout, nsh, nclr, si);
    cmp_cnt++;
    if (lat !== 2 || nsh !== 0 || nclr !== 0 || dout !== ~v) begin
      fail_cnt++;
      $display("FAIL reserved_mode: got lat %0d en %0d clr %0d data %h want 2 0 0 %h",
               lat, nsh, nclr, dout, ~v);
    end
  endtask

  task automatic test_ignore_start;
    int lat, nsh, nclr, nd; logic [W-1:0] dout, si;
    issue(2'd1, 8'h5A, 8'h00, 8'd0, 1'b0, 4, lat, dout, nsh, nclr, si);
    count_dones(15, nd);
    cmp_cnt++;
    if (lat !== W + 2 || dout !== 8'h5A) begin
      fail_cnt++; $display("FAIL ignore_start: got lat %0d data %h want %0d 5a", lat, dout, W + 2);
    end
    cmp_cnt++;
    if (nd !== 0) begin fail_cnt++; $display("FAIL ignore_extra_done: got %0d want 0", nd); end
    model_q = 8'h5A;
  endtask

  task automatic test_reset_abort;
    int lat, nsh, nclr, nd; logic [W-1:0] dout, si;
    @(negedge clock);
    start = 1'b1; mode = 2'd1; data_in = 8'h3C;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(negedge clock);
    cmp_cnt++;
    if (busy !== 1'b1 || sr_shift_en !== 1'b1) begin
      fail_cnt++; $display("FAIL abort_precond: got busy %b en %b want 1 1", busy, sr_shift_en);
    end
    #1 r = 1'b0;
    #1;
    cmp_cnt++;
    if (busy !== 1'b0 || sr_shift_en !== 1'b0 || data_out !== '0) begin
      fail_cnt++;
      $display("FAIL abort_async: got busy %b en %b data %h want 0 0 00", busy, sr_shift_en, data_out);
    end
    @(negedge clock);
    r = 1'b1;
    count_dones(15, nd);
    cmp_cnt++;
    if (nd !== 0) begin fail_cnt++; $display("FAIL abort_no_done: got %0d want 0", nd); end
    issue(2'd1, 8'hC3, 8'h00, 8'd0, 1'b0, 0, lat, dout, nsh, nclr, si);
    cmp_cnt++;
    if (lat !== W + 2 || dout !== 8'hC3) begin
      fail_cnt++; $display("FAIL abort_recover: got lat %0d data %h want %0d c3", lat, dout, W + 2);
    end
    model_q = 8'hC3;
  endtask

  task automatic test_back_to_back;
    int lat, nsh, nclr, elat, ensh; logic [W-1:0] dout, si;
    logic [1:0] ms [3]; logic [W-1:0] ds [3]; logic [7:0] ls [3];
    ms = '{2'd1, 2'd2, 2'd0}; ds = '{8'h96, 8'h00, 8'h00}; ls = '{8'd0, 8'd7, 8'd0};
    for (int i = 0; i < 3; i++) begin
      model(ms[i], ds[i], 8'h8E, int'(ls[i]), model_q, elat, ensh);
      issue(ms[i], ds[i], 8'h8E, ls[i], (i != 0), 0, lat, dout, nsh, nclr, si);
      cmp_cnt++;
      if (lat !== elat || dout !== model_q || nsh !== ensh) begin
        fail_cnt++;
        $display("FAIL b2b_cmd%0d: got lat %0d data %h en %0d want %0d %h %0d",
                 i, lat, dout, nsh, elat, model_q, ensh);
      end
    end
  endtask

  task automatic test_random;
    int lat, nsh, nclr, elat, ensh, len; logic [W-1:0] dout, si, d, t; logic [1:0] m;
    preload(W'($urandom));
    for (int i = 0; i < 40; i++) begin
      m   = 2'($urandom_range(0, 3));
      d   = W'($urandom);
      t   = W'($urandom);
      len = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
      model(m, d, t, len, model_q, elat, ensh);
      issue(m, d, t, 8'(len), bit'($urandom_range(0, 1)), 0, lat, dout, nsh, nclr, si);
      cmp_cnt++;
      if (lat !== elat || dout !== model_q || nsh !== ensh) begin
        fail_cnt++;
        $display("FAIL random_%0d mode %0d len %0d: got lat %0d data %h en %0d want %0d %h %0d",
                 i, m, len, lat, dout, nsh, elat, model_q, ensh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_load();
    test_lfsr_known();
    test_lockup();
    test_zero_len_reserved();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
